// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline stage registers and hazard_ctrl.
// master = pipeline side (drives RR/EX/MEM status), slave = controller side.
interface hazard_ctrl_if;
    logic       rr_valid;
    logic [6:0] rr_opcode;
    logic [4:0] rr_rs1;
    logic [4:0] rr_rs2;
    logic [4:0] rr_rd;
    logic       ex_redirect;
    logic       mem_busy;
    logic       pc_stall;
    logic       rr_stall;
    logic       ex_bubble;
    logic       flush;

    modport master (
        output rr_valid, rr_opcode, rr_rs1, rr_rs2, rr_rd, ex_redirect, mem_busy,
        input  pc_stall, rr_stall, ex_bubble, flush
    );

    modport slave (
        input  rr_valid, rr_opcode, rr_rs1, rr_rs2, rr_rd, ex_redirect, mem_busy,
        output pc_stall, rr_stall, ex_bubble, flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/redirect controller: EX/MEM/WB destination scoreboard, RAW stalls, flush sequencing.
// Optional macro FORWARD_EN: only load-use against the EX slot stalls (MEM/WB are forwarded).
module hazard_ctrl #(
    parameter int unsigned FLUSH_EXTRA = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    hazard_ctrl_if.slave bus
);
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        pend_reg, pend_next;
    slot_t [2:0] slot_reg;          // [0]=EX, [1]=MEM, [2]=WB
    slot_t       rr_slot;

    logic        uses_rs1, uses_rs2, writes_rd, is_load;
    logic        need_rs1, need_rs2;
    logic [2:0]  block;
    logic        hazard, redirect, issue;

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (bus.rr_opcode)
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
            default: ;
        endcase
    end

    // x0 is hardwired, so reading it can never depend on an older write
    assign need_rs1 = uses_rs1 & (bus.rr_rs1 != 5'd0);
    assign need_rs2 = uses_rs2 & (bus.rr_rs2 != 5'd0);

    for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
        assign block[gi] = slot_reg[gi].valid
                         & ((need_rs1 & (bus.rr_rs1 == slot_reg[gi].rd))
                          | (need_rs2 & (bus.rr_rs2 == slot_reg[gi].rd)))
                         & (!FWD || ((gi == 0) && slot_reg[gi].load));
    end

    assign hazard   = bus.rr_valid & (|block);
    assign redirect = (bus.ex_redirect | pend_reg) & ~bus.mem_busy;
    assign issue    = bus.rr_valid & ~hazard & ~bus.mem_busy & (state_reg == RUN)
                    & ~bus.ex_redirect & ~pend_reg;

    always_comb begin
        rr_slot = '0;
        if (issue) begin
            rr_slot.valid = writes_rd & (bus.rr_rd != 5'd0);
            rr_slot.rd    = bus.rr_rd;
            rr_slot.load  = is_load;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        if (bus.ex_redirect && bus.mem_busy) begin
            pend_next = 1'b1;
        end
        // A fresh redirect restarts the flush window even if one is running
        if (redirect) begin
            pend_next = 1'b0;
            if (FLUSH_EXTRA == 0) begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end else begin
                state_next = FLUSH;
                cnt_next   = 3'(FLUSH_EXTRA);
            end
        end else if (state_reg == FLUSH && !bus.mem_busy) begin
            if (cnt_reg <= 3'd1) begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end else begin
                cnt_next = cnt_reg - 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_reg <= '0;
        end else if (!bus.mem_busy) begin
            slot_reg <= {slot_reg[1], slot_reg[0], rr_slot};
        end
    end

    always_comb begin
        bus.pc_stall  = 1'b0;
        bus.rr_stall  = 1'b0;
        bus.ex_bubble = 1'b0;
        bus.flush     = 1'b0;
        if (!reset_n) begin
            bus.flush = 1'b1;
        end else if (bus.mem_busy) begin
            bus.pc_stall = 1'b1;
            bus.rr_stall = 1'b1;
        end else if (redirect || state_reg == FLUSH) begin
            bus.flush     = 1'b1;
            bus.ex_bubble = 1'b1;
        end else if (hazard) begin
            bus.pc_stall  = 1'b1;
            bus.rr_stall  = 1'b1;
            bus.ex_bubble = 1'b1;
        end else begin
            bus.ex_bubble = ~bus.rr_valid;
        end
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and redirect controller for the in-order core; it sequences the IF, RR (register-read/decode) and EX stage registers. It tracks in-flight destination registers in an internal three-slot scoreboard (EX/MEM/WB), detects read-after-write hazards against the instruction currently in RR, and drives stall, bubble and flush controls. It also serialises control-flow redirects from EX against multi-cycle memory waits.

## Interface
- FLUSH_EXTRA, 1: cycles that `flush` remains asserted after the redirect cycle (0–7).
- clock  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rr_valid  in  1  RR stage holds a live instruction.
- rr_opcode  in  7  inst[6:0] of the RR instruction.
- rr_rs1, rr_rs2  in  5  source register fields of the RR instruction.
- rr_rd  in  5  destination field of the RR instruction.
- ex_redirect  in  1  one-cycle pulse from EX: taken branch, JAL or JALR.
- mem_busy  in  1  memory stage is not ready; the whole pipe must hold.
- pc_stall  out  1  hold the PC and IF/RR register.
- rr_stall  out  1  hold the RR-stage outputs (inst_out, imm, selects).
- ex_bubble  out  1  load NOP / `ZERO_REG` into EX instead of the RR instruction.
- flush  out  1  replace the IF and RR contents with NOP.

## Operation
- Source use: OP, BRANCH and STORE read rs1 and rs2. OP_IMM, JALR and LOAD read rs1 only. LUI, AUIPC and JAL read none. Any other opcode reads none. A source of x0 never hazards.
- Destination write: OP, OP_IMM, LUI, AUIPC, JAL, JALR and LOAD write rd when rd != 0. A LOAD also sets the slot's load bit.
- Each scoreboard slot holds {valid, rd[4:0], load}.
- Issue is `rr_valid & ~hazard & ~mem_busy & state==RUN & ~ex_redirect & ~pend`.
- Slot advance, when mem_busy=0: wb<=mem; mem<=ex; ex<=issue ? RR info : empty. When mem_busy=1, all slots hold.
- Hazard rule depends on FORWARD_EN (see Configuration).
- State machine:
  - RUN: a redirect (ex_redirect, or pend with mem_busy=0) → FLUSH with cnt=FLUSH_EXTRA. If FLUSH_EXTRA=0, stay in RUN.
  - FLUSH: cnt decrements each cycle with mem_busy=0. Return to RUN when cnt reaches 1.
- `pend` flag: set when ex_redirect arrives while mem_busy=1. Cleared when the redirect is applied.
- Output priority, highest first: mem_busy, redirect, FLUSH state, hazard.
  - mem_busy=1: pc_stall=rr_stall=1; ex_bubble=0; flush=0.
  - Redirect applied (ex_redirect, or pend with mem_busy=0): flush=1; ex_bubble=1; pc_stall=rr_stall=0.
  - FLUSH state: flush=1; ex_bubble=1; pc_stall=rr_stall=0.
  - Hazard: pc_stall=rr_stall=1; ex_bubble=1; flush=0.
  - Otherwise: all outputs 0.
- rr_valid=0 never stalls. When rr_valid=0, ex receives an empty slot and ex_bubble=1.

## Timing
- All outputs are combinational from the inputs and registered state, valid in the same cycle. There is no added latency.
- Reset (reset_n low, asynchronous): all slots invalid; state=RUN; cnt=0; pend=0. While in reset, flush=1 and the other outputs are 0.
- Reset deasserted mid-stall or mid-flush: the next cycle starts in RUN with an empty scoreboard.
- A redirect lasts 1+FLUSH_EXTRA flush cycles, extended by any mem_busy cycles inside the window.
- ex_redirect and a hazard in the same cycle: the redirect wins and the hazard instruction is flushed.
- ex_redirect while pend=1 and mem_busy=1: pend stays 1, so redirects merge into one.
- A hazard stall lasts until the blocking slot leaves the compared set. With forwarding this is 1 cycle for load-use. Without forwarding it is at most 3 cycles.

## Configuration
- FORWARD_EN defined: a hazard occurs only when a used source equals ex.rd with ex.valid & ex.load (load-use). MEM and WB are covered by forwarding.
- FORWARD_EN undefined: a hazard occurs when a used source equals the rd of any valid ex, mem or wb slot.

## Test plan
- LOAD x5 issued, then `add x6,x5,x1` in RR. With FORWARD_EN: exactly 1 cycle of pc_stall/rr_stall/ex_bubble. Without it: 3 cycles.
- `addi x0,...` followed by a reader of x0, and LUI x7 followed by JAL: zero stall cycles in both configurations.
- ex_redirect pulse with FLUSH_EXTRA=1: flush=1 and ex_bubble=1 for exactly 2 cycles, then issue resumes.
- ex_redirect while mem_busy=1 for 3 cycles: stalls only during the wait. flush rises the cycle mem_busy falls and lasts 2 cycles.
- Load-use hazard and ex_redirect in the same cycle: flush=1, pc_stall=0, and the scoreboard ex slot is empty next cycle.
- reset_n pulsed low during the FLUSH state with a valid scoreboard: all outputs except flush drop immediately. After release, a dependent pair shows no stale stall.
